// File: rtl/mux_scan_controller.sv
`timescale 1ns/1ps
// mux_scan_controller: sequences an 8:1 mux (active-high disable, 3-bit select)
// through all eight inputs, waits SETTLE cycles per select value, samples Z and
// presents the eight samples as one byte on a VALID/ACK handshake.
module mux_scan_controller #(
  // Cycles S is held stable before Z is sampled; legal range 1..15.
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic       Z,
  output logic       E,
  output logic [2:0] S,
  output logic [7:0] D,
  output logic       VALID,
  input  logic       ACK,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  // Last counter value spent in SETTLE; the counter width covers SETTLE up to 15.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [2:0]  s_q,     s_d;
  logic        e_q,     e_d;
  logic [7:0]  d_q,     d_d;
  logic        valid_q, valid_d;
  logic        busy_q,  busy_d;
  logic [7:0]  buf_q,   buf_d;

  // State and registered outputs; reset discards any partial scan immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      s_q     <= 3'd0;
      e_q     <= 1'b1;
      d_q     <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      buf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      e_q     <= e_d;
      d_q     <= d_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state and next-output logic; every register holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    e_d     = e_q;
    d_d     = d_q;
    valid_d = valid_q;
    buf_d   = buf_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETTLE;
          e_d     = 1'b0;
          s_d     = 3'd0;
          cnt_d   = 4'd0;
          buf_d   = 8'h00;
        end
      end

      ST_SETTLE: begin
        if (ABORT) begin
          // Cancel: mux disabled, partial buffer dropped, D/VALID untouched.
          state_d = ST_IDLE;
          e_d     = 1'b1;
          s_d     = 3'd0;
          cnt_d   = 4'd0;
          buf_d   = 8'h00;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (ABORT) begin
          // Abort wins over the capture in the same edge.
          state_d = ST_IDLE;
          e_d     = 1'b1;
          s_d     = 3'd0;
          cnt_d   = 4'd0;
          buf_d   = 8'h00;
        end else begin
          buf_d[s_q] = Z;
          if (s_q == 3'd7) begin
            // Last bit comes straight from Z since buf_q does not hold it yet.
            d_d     = {Z, buf_q[6:0]};
            valid_d = 1'b1;
            e_d     = 1'b1;
            s_d     = 3'd0;
            state_d = ST_HOLD;
          end else begin
            s_d     = s_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = ST_SETTLE;
          end
        end
      end

      ST_HOLD: begin
        // START is deliberately ignored here; a restart must be seen in IDLE.
        if (ACK) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        e_d     = 1'b1;
        s_d     = 3'd0;
      end
    endcase

    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
  end

  assign E     = e_q;
  assign S     = s_q;
  assign D     = d_q;
  assign VALID = valid_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
`timescale 1ns/1ps
// Bench for mux_scan_controller: two instances (SETTLE=1 and SETTLE=3), each
// driven by a behavioural 8:1 mux model; expected outputs are derived from the
// cycle number within a scan.
module tb_mux_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_n_v, start_v, abort_v, ack_v, z_v, e_v, valid_v, busy_v;
  logic [1:0]      noise_v, rnd_v;
  logic [1:0][2:0] s_v;
  logic [1:0][7:0] d_v, pat_v;
  logic [7:0]      exp_d [2];

  int checks   = 0;
  int failures = 0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      // Mux model: disabled forces 0; noise replaces the selected input outside the sample cycle.
      assign z_v[gi] = e_v[gi] ? 1'b0 : (noise_v[gi] ? rnd_v[gi] : pat_v[gi][s_v[gi]]);

      mux_scan_controller #(.SETTLE((gi == 0) ? 1 : 3)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n_v[gi]),
        .START (start_v[gi]),
        .ABORT (abort_v[gi]),
        .Z     (z_v[gi]),
        .E     (e_v[gi]),
        .S     (s_v[gi]),
        .D     (d_v[gi]),
        .VALID (valid_v[gi]),
        .ACK   (ack_v[gi]),
        .BUSY  (busy_v[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int idx, input string tag);
    check({tag, ".E"},     32'(e_v[idx]),     32'd1);
    check({tag, ".S"},     32'(s_v[idx]),     32'd0);
    check({tag, ".BUSY"},  32'(busy_v[idx]),  32'd0);
    check({tag, ".VALID"}, 32'(valid_v[idx]), 32'd0);
    check({tag, ".D"},     32'(d_v[idx]),     32'(exp_d[idx]));
  endtask

  // One scan from IDLE; abort_at = cycle index (0-based after the START edge) to pulse ABORT, -1 for none.
  task automatic run_scan(input int idx, input logic [7:0] pat, input bit noise,
                          input int abort_at, input string tag);
    int p;
    int n;
    p = settle_of(idx);
    n = 8 * (p + 1);
    pat_v[idx]   = pat;
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({tag, ".scanE"},     32'(e_v[idx]),     32'd0);
      check({tag, ".scanS"},     32'(s_v[idx]),     32'(k / (p + 1)));
      check({tag, ".scanBUSY"},  32'(busy_v[idx]),  32'd1);
      check({tag, ".scanVALID"}, 32'(valid_v[idx]), 32'd0);
      noise_v[idx] = noise && ((k % (p + 1)) < p);
      rnd_v[idx]   = 1'($urandom);
      if (k == abort_at) abort_v[idx] = 1'b1;
      tick();
      abort_v[idx] = 1'b0;
      noise_v[idx] = 1'b0;
      if (k == abort_at) begin
        check_idle(idx, {tag, ".abort"});
        $display("txn %s inst=%0d abort at cycle %0d D=%02h", tag, idx, k, d_v[idx]);
        return;
      end
    end
    exp_d[idx] = pat;
    check({tag, ".doneVALID"}, 32'(valid_v[idx]), 32'd1);
    check({tag, ".doneD"},     32'(d_v[idx]),     32'(pat));
    check({tag, ".doneE"},     32'(e_v[idx]),     32'd1);
    check({tag, ".doneS"},     32'(s_v[idx]),     32'd0);
    check({tag, ".doneBUSY"},  32'(busy_v[idx]),  32'd0);
    $display("txn %s inst=%0d scan pat=%02h D=%02h", tag, idx, pat, d_v[idx]);
  endtask

  // Hold VALID for wait_cycles (START toggled randomly, must be ignored), then ACK.
  task automatic hold_ack(input int idx, input int wait_cycles, input bit start_with_ack,
                          input string tag);
    for (int w = 0; w < wait_cycles; w++) begin
      start_v[idx] = 1'($urandom);
      tick();
      check({tag, ".holdVALID"}, 32'(valid_v[idx]), 32'd1);
      check({tag, ".holdD"},     32'(d_v[idx]),     32'(exp_d[idx]));
      check({tag, ".holdBUSY"},  32'(busy_v[idx]),  32'd0);
      check({tag, ".holdE"},     32'(e_v[idx]),     32'd1);
    end
    ack_v[idx]   = 1'b1;
    start_v[idx] = start_with_ack;
    tick();
    ack_v[idx]   = 1'b0;
    start_v[idx] = 1'b0;
    check_idle(idx, {tag, ".ack"});
    if (start_with_ack) begin
      tick();
      check_idle(idx, {tag, ".ackstart"});
    end
    $display("txn %s inst=%0d ack after %0d cycles", tag, idx, wait_cycles);
  endtask

  task automatic reset_mid(input int idx, input string tag);
    int p;
    p = settle_of(idx);
    pat_v[idx]   = 8'($urandom);
    start_v[idx] = 1'b1;
    tick();
    start_v[idx] = 1'b0;
    repeat (5 * (p + 1)) tick();
    check({tag, ".preS"}, 32'(s_v[idx]), 32'd5);
    #2;
    rst_n_v[idx] = 1'b0;
    #1;
    exp_d[idx] = 8'h00;
    check_idle(idx, {tag, ".async"});
    tick();
    rst_n_v[idx] = 1'b1;
    repeat (5) begin
      tick();
      check_idle(idx, {tag, ".idle"});
    end
    $display("txn %s inst=%0d async reset at S=5", tag, idx);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ab;
    rst_n_v = 2'b00; start_v = 2'b00; abort_v = 2'b00; ack_v = 2'b00;
    noise_v = 2'b00; rnd_v = 2'b00; pat_v = '0;
    exp_d[0] = 8'h00; exp_d[1] = 8'h00;
    tick();
    tick();
    for (int i = 0; i < 2; i++) check_idle(i, "reset");
    rst_n_v = 2'b11;
    tick();
    for (int i = 0; i < 2; i++) check_idle(i, "postreset");

    // Basic scan, SETTLE=1
    run_scan(0, 8'hA5, 1'b0, -1, "basic");
    hold_ack(0, 2, 1'b0, "basic");
    // Settle timing with Z noise, SETTLE=3
    run_scan(1, 8'h3C, 1'b1, -1, "settle");
    hold_ack(1, 1, 1'b0, "settle");
    // Handshake hold, then restart on the edge after ACK
    run_scan(0, 8'hFF, 1'b0, -1, "hold");
    hold_ack(0, 10, 1'b0, "hold");
    run_scan(0, 8'h12, 1'b0, -1, "restart");
    hold_ack(0, 0, 1'b0, "restart");
    // Abort in SAMPLE while S=3
    run_scan(0, 8'h00, 1'b0, 3 * 2 + 1, "abort");
    run_scan(0, 8'h81, 1'b0, -1, "rescan");
    hold_ack(0, 1, 1'b0, "rescan");
    // Async reset mid-scan
    reset_mid(0, "rstmid");
    // ACK and START together, then a full scan
    run_scan(0, 8'hC3, 1'b0, -1, "b2b1");
    hold_ack(0, 1, 1'b1, "b2b1");
    run_scan(0, 8'h5A, 1'b0, -1, "b2b2");
    hold_ack(0, 0, 1'b0, "b2b2");

    // Randomised scans on both instances
    for (int it = 0; it < 40; it++) begin
      int idx;
      idx = it % 2;
      ack_v[idx] = 1'b1;
      tick();
      ack_v[idx] = 1'b0;
      check_idle(idx, "ackidle");
      n  = 8 * (settle_of(idx) + 1);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_scan(idx, 8'($urandom), 1'($urandom), ab, "rand");
      if (ab < 0) hold_ack(idx, int'($urandom_range(0, 4)), 1'($urandom), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequencer for an 8:1 multiplexer with an active-high disable and a 3-bit select (74LS151-style datapath). On request, it enables the mux and steps the select S through 0..7. At each step it waits a programmable settle time, then samples the mux output Z. The eight samples are packed into a byte and delivered on a VALID/ACK handshake. It sits between the mux and any consumer that needs the eight mux inputs as a parallel word.

Parameters:
SETTLE, 1, cycles S is held stable before Z is sampled; legal range 1..15.

Ports:
CLK  input  1  single system clock; all state changes on rising edge
RST_N  input  1  asynchronous, active-low reset
START  input  1  scan request; sampled only in IDLE
ABORT  input  1  synchronous scan cancel
Z  input  1  mux data output (non-inverted)
E  output  1  mux disable; 1 = mux disabled (Z forced 0), 0 = enabled
S  output  3  mux select
D  output  8  captured byte; D[n] = Z sampled while S = n
VALID  output  1  D holds a complete, unconsumed byte
ACK  input  1  consumer accepts D
BUSY  output  1  scan in progress (SETTLE or SAMPLE state)

Behaviour:
- Reset (RST_N=0, takes effect immediately, no clock needed):
  - State goes to IDLE.
  - E=1, S=0, D=8'h00, VALID=0, BUSY=0.
  - Internal shift buffer and settle counter cleared.
  - Any partial scan is discarded.
- States:
  - IDLE
  - SETTLE
  - SAMPLE
  - HOLD (VALID asserted, waiting for ACK)
- All outputs are registered. BUSY=1 exactly in SETTLE and SAMPLE.
- IDLE:
  - E=1, S=0.
  - START=1 at an edge → SETTLE; E=0 and S=0 from that edge; settle counter = 0.
- SETTLE:
  - Counter increments each edge.
  - When counter = SETTLE-1 → SAMPLE. This gives exactly SETTLE cycles with S stable before sampling.
- SAMPLE (one cycle): at the closing edge, buffer[S] ← Z.
  - If S < 7: S ← S+1, counter ← 0, → SETTLE.
  - If S = 7: D ← buffer including the Z just sampled (bit 7), VALID ← 1, E ← 1, S ← 0 → HOLD.
- Latency: VALID rises exactly 8×(SETTLE+1) edges after the edge that accepted START. With SETTLE=1 this is 16 edges.
- HOLD:
  - D and VALID are held stable; START is ignored.
  - ACK=1 at an edge → VALID=0 from that edge, → IDLE. D keeps its last value.
  - START is never accepted in the same edge as ACK; it must be seen in IDLE, so the earliest restart is the edge after ACK.
- ACK while VALID=0: ignored.
- ABORT:
  - In SETTLE or SAMPLE: next edge → IDLE, E=1, S=0, buffer cleared. D and VALID are unchanged, so no partial byte is ever presented.
  - Ignored in IDLE and HOLD.
  - ABORT has priority over the SAMPLE capture in the same edge.
- Z is sampled only at the SAMPLE edge; changes of Z at other times have no effect.
- S never exceeds 7 and never wraps during a scan; S=0 whenever E=1.
- E=0 only in SETTLE and SAMPLE.

Test Plan:
1. Basic scan: SETTLE=1, mux model with I=8'hA5, one-cycle START pulse.
   → E falls the next edge; S steps 0,0,1,1,…,7,7.
   → VALID rises 16 edges after the START edge with D=8'hA5; E=1 and S=0 at that edge; BUSY high for exactly 16 cycles.
2. Settle timing: SETTLE=3, I=8'h3C.
   → Each S value held 4 cycles; VALID at edge 32; D=8'h3C.
   → Toggling Z during the first 3 cycles of each step does not change D.
3. Handshake hold: after a scan with D=8'hFF, hold ACK=0 for 10 cycles and pulse START.
   → VALID stays 1, D stays 8'hFF, BUSY stays 0, no new scan.
   → ACK=1 at one edge → VALID=0 at that edge; START on the next edge begins a new scan.
4. Abort mid-scan: previous D=8'h12, new scan with I=8'h00; assert ABORT for one cycle while S=3 (SAMPLE).
   → Next edge E=1, S=0, BUSY=0; VALID stays 0 and D stays 8'h12.
   → Rescan with I=8'h81 yields D=8'h81.
5. Async reset mid-scan: drop RST_N between edges while S=5.
   → E=1, S=0, BUSY=0, VALID=0, D=8'h00 immediately, with no clock edge.
   → After release, the block idles until START.
6. Back-to-back: pulse ACK and START in the same cycle while in HOLD.
   → START is ignored.
   → START on the following edge runs a full scan; the second D matches the new I pattern 8'h5A.
